// File: rtl/debug_ocimem_arbiter.sv
// Shares the debug monitor RAM between JTAG debug-slave commands and the CPU debug slave port.
// Owns the JTAG address pointer, MonDReg and the monitor_ready/monitor_error flags.
module debug_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              jtag_addr_load,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic              jtag_rd,
    input  logic              jtag_wr,
    input  logic [DATA_W-1:0] jtag_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              jtag_busy
);

    typedef enum logic [2:0] {
        IDLE, JRD, JRD_DATA, JWR, CRD, CRD_DATA, CWR
    } state_t;

    typedef struct packed {
        logic              vld;
        logic              op;    // 1 = write
        logic [DATA_W-1:0] wdata;
    } jreq_t;

    state_t            state, state_nxt;
    jreq_t             pend;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] rd_hold;
    logic              last_grant;  // 1 = JTAG won the last grant

    logic j_state, cap, drop, done, jreq, jop, creq, grant_j, grant_c;

    assign j_state = (state == JRD) || (state == JRD_DATA) || (state == JWR);
    assign cap     = (jtag_rd ^ jtag_wr) && !pend.vld && !j_state;
    assign drop    = (jtag_rd || jtag_wr) && !cap;
    assign done    = (state == JRD_DATA) || (state == JWR);

    // A strobe arriving in IDLE competes in that same cycle, so an uncontended
    // command skips the pending-register round trip.
    assign jreq = pend.vld || cap;
    assign jop  = pend.vld ? pend.op : jtag_wr;
    assign creq = cpu_read || cpu_write;

    always_comb begin
        state_nxt = state;
        grant_j   = 1'b0;
        grant_c   = 1'b0;
        case (state)
            IDLE: begin
                if (jreq && creq) begin
                    grant_j = !last_grant;
                    grant_c = last_grant;
                end else begin
                    grant_j = jreq;
                    grant_c = creq;
                end
                if (grant_j)      state_nxt = jop ? JWR : JRD;
                else if (grant_c) state_nxt = cpu_read ? CRD : CWR;
            end
            JRD:      state_nxt = JRD_DATA;
            CRD:      state_nxt = CRD_DATA;
            JRD_DATA,
            JWR,
            CRD_DATA,
            CWR:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pend          <= '0;
            ptr           <= '0;
            MonDReg       <= '0;
            rd_hold       <= '0;
            last_grant    <= 1'b0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_j)      last_grant <= 1'b1;
            else if (grant_c) last_grant <= 1'b0;

            if (done)     pend.vld <= 1'b0;
            else if (cap) pend     <= '{vld: 1'b1, op: jtag_wr, wdata: jtag_wdata};

            if (jtag_addr_load) ptr <= jtag_addr;
            else if (done)      ptr <= ptr + 1'b1;

            if (state == JRD_DATA) MonDReg <= ram_rdata;
            if (state == CRD_DATA) rd_hold <= ram_rdata;

            if (cap)       monitor_ready <= 1'b0;
            else if (done) monitor_ready <= 1'b1;

            // Load clears first; a colliding dropped command still flags.
            if (drop)                monitor_error <= 1'b1;
            else if (jtag_addr_load) monitor_error <= 1'b0;
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state)
            JRD: begin
                ram_addr = ptr;
                ram_re   = 1'b1;
            end
            JWR: begin
                ram_addr  = ptr;
                ram_wdata = pend.wdata;
                ram_we    = 1'b1;
            end
            CRD: begin
                ram_addr = cpu_address;
                ram_re   = 1'b1;
            end
            CWR: begin
                ram_addr  = cpu_address;
                ram_wdata = cpu_writedata;
                ram_we    = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_readdata    = (state == CRD_DATA) ? ram_rdata : rd_hold;
    assign cpu_waitrequest = creq && !((state == CWR) || (state == CRD_DATA));
    assign jtag_busy       = pend.vld || j_state;

endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Directed bench for debug_ocimem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_debug_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        jtag_addr_load = 1'b0;
    logic [7:0]  jtag_addr = '0;
    logic        jtag_rd = 1'b0;
    logic        jtag_wr = 1'b0;
    logic [31:0] jtag_wdata = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_address = '0;
    logic [31:0] cpu_writedata = '0;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata = '0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        jtag_busy;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    logic [31:0] mem [256];

    debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .jtag_addr_load(jtag_addr_load), .jtag_addr(jtag_addr),
        .jtag_rd(jtag_rd), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
        .cpu_waitrequest(cpu_waitrequest),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata), .MonDReg(MonDReg),
        .monitor_ready(monitor_ready), .monitor_error(monitor_error), .jtag_busy(jtag_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (ram_re) begin
            ram_rdata <= mem[ram_addr];
            re_cnt <= re_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int we0, re0, falls, fall_at;
        logic [31:0] rd_seen;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h11] = 32'hA5A50011;
        mem[8'hFF] = 32'h12345678;
        mem[8'h02] = 32'h00000222;

        // reset state
        #12;
        chk("rst_ready", {31'b0, monitor_ready}, 32'h0);
        chk("rst_error", {31'b0, monitor_error}, 32'h0);
        chk("rst_busy", {31'b0, jtag_busy}, 32'h0);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_rdata", cpu_readdata, 32'h0);
        chk("rst_ram_ctl", {30'b0, ram_we, ram_re}, 32'h0);
        chk("rst_wait", {31'b0, cpu_waitrequest}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // load 0x10, write 0xDEADBEEF
        jtag_addr_load = 1'b1; jtag_addr = 8'h10;
        tick();
        jtag_addr_load = 1'b0;
        jtag_wr = 1'b1; jtag_wdata = 32'hDEADBEEF;
        tick();
        jtag_wr = 1'b0;
        chk("jwr_we", {31'b0, ram_we}, 32'h1);
        chk("jwr_addr", {24'b0, ram_addr}, 32'h10);
        chk("jwr_wdata", ram_wdata, 32'hDEADBEEF);
        chk("jwr_busy", {31'b0, jtag_busy}, 32'h1);
        chk("jwr_ready_early", {31'b0, monitor_ready}, 32'h0);
        tick();
        chk("jwr_ready", {31'b0, monitor_ready}, 32'h1);
        chk("jwr_mem", mem[8'h10], 32'hDEADBEEF);
        chk("jwr_busy_done", {31'b0, jtag_busy}, 32'h0);

        // read at incremented pointer 0x11
        jtag_rd = 1'b1;
        tick();
        jtag_rd = 1'b0;
        chk("jrd_re", {31'b0, ram_re}, 32'h1);
        chk("jrd_ptr_inc", {24'b0, ram_addr}, 32'h11);
        chk("jrd_ready_clr", {31'b0, monitor_ready}, 32'h0);
        tick();
        chk("jrd_data_ready", {31'b0, monitor_ready}, 32'h0);
        tick();
        chk("jrd_ready", {31'b0, monitor_ready}, 32'h1);
        chk("jrd_mondreg", MonDReg, 32'hA5A50011);

        // pointer wrap at 0xFF
        jtag_addr_load = 1'b1; jtag_addr = 8'hFF;
        tick();
        jtag_addr_load = 1'b0;
        jtag_rd = 1'b1;
        tick();
        jtag_rd = 1'b0;
        chk("wrap_rd_addr", {24'b0, ram_addr}, 32'hFF);
        tick();
        tick();
        chk("wrap_ready", {31'b0, monitor_ready}, 32'h1);
        chk("wrap_mondreg", MonDReg, 32'h12345678);
        jtag_wr = 1'b1; jtag_wdata = 32'h0BADF00D;
        tick();
        jtag_wr = 1'b0;
        chk("wrap_ptr0", {24'b0, ram_addr}, 32'h00);
        tick();
        chk("wrap_mem0", mem[8'h00], 32'h0BADF00D);

        // CPU write: 2 cycles including arbitration
        cpu_write = 1'b1; cpu_address = 8'h20; cpu_writedata = 32'hCAFE0020;
        #1;
        chk("cwr_wait_idle", {31'b0, cpu_waitrequest}, 32'h1);
        tick();
        chk("cwr_wait", {31'b0, cpu_waitrequest}, 32'h0);
        chk("cwr_we", {31'b0, ram_we}, 32'h1);
        chk("cwr_addr", {24'b0, ram_addr}, 32'h20);
        cpu_write = 1'b0;
        tick();
        chk("cwr_mem", mem[8'h20], 32'hCAFE0020);

        // contention: CPU read held + jtag_wr, JTAG wins (last grant was CPU)
        cpu_read = 1'b1; cpu_address = 8'h20;
        jtag_wr = 1'b1; jtag_wdata = 32'h55AA55AA;
        falls = 0; fall_at = -1; rd_seen = '0;
        tick();
        jtag_wr = 1'b0;
        chk("cont_jtag_first", {30'b0, ram_we, ram_re}, 32'h2);
        chk("cont_jtag_addr", {24'b0, ram_addr}, 32'h01);
        for (int c = 1; c <= 10 && cpu_read; c++) begin
            if (!cpu_waitrequest) begin
                falls++;
                fall_at = c;
                rd_seen = cpu_readdata;
                cpu_read = 1'b0;
            end
            tick();
        end
        if (cpu_read) cpu_read = 1'b0;
        chk("cont_wait_falls", falls, 32'd1);
        chk("cont_fall_cycle", fall_at, 32'd4);
        chk("cont_rdata", rd_seen, 32'hCAFE0020);
        chk("cont_rdata_hold", cpu_readdata, 32'hCAFE0020);
        chk("cont_jmem", mem[8'h01], 32'h55AA55AA);
        chk("cont_ready", {31'b0, monitor_ready}, 32'h1);

        // rd then wr one cycle later: second dropped
        we0 = we_cnt;
        jtag_rd = 1'b1;
        tick();
        jtag_rd = 1'b0;
        jtag_wr = 1'b1; jtag_wdata = 32'hFFFFFFFF;
        tick();
        jtag_wr = 1'b0;
        chk("drop_error", {31'b0, monitor_error}, 32'h1);
        tick();
        tick();
        chk("drop_mondreg", MonDReg, 32'h00000222);
        chk("drop_mem", mem[8'h02], 32'h00000222);
        chk("drop_no_we", we_cnt - we0, 32'd0);
        chk("drop_busy", {31'b0, jtag_busy}, 32'h0);
        jtag_addr_load = 1'b1; jtag_addr = 8'h40;
        tick();
        jtag_addr_load = 1'b0;
        chk("load_clr_error", {31'b0, monitor_error}, 32'h0);

        // simultaneous rd+wr
        we0 = we_cnt; re0 = re_cnt;
        jtag_rd = 1'b1; jtag_wr = 1'b1;
        tick();
        jtag_rd = 1'b0; jtag_wr = 1'b0;
        chk("both_error", {31'b0, monitor_error}, 32'h1);
        chk("both_busy", {31'b0, jtag_busy}, 32'h0);
        tick();
        tick();
        chk("both_no_ram", (we_cnt - we0) + (re_cnt - re0), 32'd0);
        chk("both_ready_kept", {31'b0, monitor_ready}, 32'h1);

        // reset during CRD
        cpu_read = 1'b1; cpu_address = 8'h20;
        tick();
        chk("crd_re", {31'b0, ram_re}, 32'h1);
        we0 = we_cnt;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ram_ctl", {30'b0, ram_we, ram_re}, 32'h0);
        chk("arst_ram_addr", {24'b0, ram_addr}, 32'h0);
        chk("arst_ready", {31'b0, monitor_ready}, 32'h0);
        chk("arst_error", {31'b0, monitor_error}, 32'h0);
        chk("arst_mondreg", MonDReg, 32'h0);
        chk("arst_rdata", cpu_readdata, 32'h0);
        cpu_read = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("arst_no_we", we_cnt - we0, 32'd0);
        chk("arst_idle", {30'b0, ram_we, ram_re}, 32'h0);
        jtag_wr = 1'b1; jtag_wdata = 32'h77777777;
        tick();
        jtag_wr = 1'b0;
        chk("arst_ptr0", {24'b0, ram_addr}, 32'h0);
        chk("arst_jwr_we", {31'b0, ram_we}, 32'h1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
